fixed_div_ctrl: RTL
===================

Name: fixed_div_ctrl

Overview:
- Fixed-point signed division front/back end wrapped around the iterative integer divider core; sits between the ray-intersection datapath and the core.
- Accepts Q-format numerator/denominator over a valid/ready handshake, converts to scaled non-negative magnitudes and issues one request to the core.
- Waits for the core result, restores sign, saturates, flags divide-by-zero and holds the result until downstream accepts it.

Parameters:
- DATA_WIDTH, 32, width of external signed fixed-point operands and result
- QUANTIZED_BITS, 10, fractional bits of the Q format (1.0 = 2^QUANTIZED_BITS)
- DIV_WIDTH (localparam), DATA_WIDTH+QUANTIZED_BITS+1, operand width presented to the divider core

Ports:
- clock  in  1  single system clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream request valid
- in_ready  out  1  high only in IDLE
- num  in  DATA_WIDTH  signed Q dividend
- den  in  DATA_WIDTH  signed Q divisor
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts when high with out_valid
- out_quot  out  DATA_WIDTH  signed Q quotient
- out_div_zero  out  1  den was zero
- out_sat  out  1  quotient clamped
- div_valid_in  out  1  one-cycle start pulse to core
- div_dividend  out  DIV_WIDTH  |num| << QUANTIZED_BITS, zero-extended
- div_divisor  out  DIV_WIDTH  |den|, zero-extended
- div_quotient  in  DIV_WIDTH  core quotient
- div_valid_out  in  1  core done pulse

Behaviour:
- Reset (synchronous; wins over all other activity, including mid-operation): state IDLE. in_ready=1; out_valid, div_valid_in, out_div_zero and out_sat are 0; out_quot, div_dividend and div_divisor are 0.
- The core shares clock/reset, so a reset mid-operation aborts both sides; there is no partial-result output.
- States: IDLE, ISSUE, WAIT, POST, OUT.
- IDLE:
  - On in_valid & in_ready, capture sign = num[MSB]^den[MSB] and the num sign.
  - Capture magnitudes with full-width negate, so -2^(DATA_WIDTH-1) is exact in DIV_WIDTH bits.
  - If den==0, go to OUT with the div-zero result; otherwise go to ISSUE.
- ISSUE: drive div_valid_in=1 for exactly one cycle with stable div_dividend/div_divisor, then go to WAIT. Operands stay stable until POST.
- WAIT: hold until div_valid_out=1; latch div_quotient, then go to POST. div_valid_out in any other state is ignored. Exactly one request is outstanding at a time.
- POST:
  - Magnitude m = latched quotient; truncation toward zero, and the remainder is unused.
  - Positive result: if m > 2^(DATA_WIDTH-1)-1, clamp to max and set out_sat.
  - Negative result: if m > 2^(DATA_WIDTH-1), clamp to min and set out_sat; otherwise out_quot = -m.
  - Go to OUT.
- Divide-by-zero:
  - num>0 gives max, num<0 gives min, num==0 gives 0.
  - out_div_zero=1, and out_sat=1 unless num==0.
  - The core is never started.
- OUT: out_valid=1 with registered, stable outputs. On out_ready, return to IDLE next cycle; flags clear when leaving OUT. out_ready is ignored outside OUT.
- Latency from accept to out_valid: 1 (ISSUE) + core latency + 1 (WAIT capture) + 1 (POST). Div-by-zero takes 1 cycle.
- Throughput is one op per (latency + 1 + backpressure) cycles, with no overlap.
- in_ready is combinationally (state==IDLE), with no dependence on in_valid.

Decomposition:
- Shared package (fixed_pkg): the QUANTIZED_BITS/DATA_WIDTH defaults, the Q_ONE constant, and the FIX_MAX/FIX_MIN saturation constants. Also the state enum typedef div_ctrl_state_t, so debug monitors can decode the state.
- Natural sub-module: fixed_sign_mag, a combinational helper giving signed to magnitude plus sign and magnitude+sign to saturated signed, used in IDLE and POST.
- The divider core is instantiated by the parent, not inside this block.

Test Plan:
- num=3072 (3.0), den=1024 (1.0) -> core sees dividend 3145728, divisor 1024; out_quot=3072, both flags 0.
- num=-1024, den=3072 -> out_quot=-341, truncated toward zero, flags 0. Also check num=-1024, den=-3072 -> 341.
- den=0 with num=5 -> 0x7FFFFFFF, div_zero=1, sat=1, div_valid_in never asserted. num=-5 -> 0x80000000. num=0 -> 0 with div_zero=1, sat=0.
- num=0x7FFFFFFF, den=1 -> 0x7FFFFFFF, sat=1. num=0x80000000, den=1 -> 0x80000000, sat=1. num=0x80000000, den=1024 -> 0x80000000, sat=0.
- out_ready held low 20 cycles in OUT -> out_valid and out_quot stable, in_ready=0. A new in_valid during that window is not accepted; it is accepted the cycle after the handshake.
- Reset asserted in WAIT -> next cycle IDLE, out_valid=0, in_ready=1. A stray div_valid_out after reset causes no output. A following 3.0/1.0 op completes correctly.

Source files
------------

// File: rtl/fixed_pkg.sv
// fixed_pkg: values shared by the fixed-point divider controller and its
// debug monitors.
//   DATA_WIDTH_DEF / QUANTIZED_BITS_DEF : default Q-format geometry
//   Q_ONE                               : 1.0 in the default Q format
//   FIX_MAX / FIX_MIN                   : saturation limits at the default width
//   div_ctrl_state_t                    : controller state encoding, exported
//                                         so monitors can decode dbg_state_o
package fixed_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int QUANTIZED_BITS_DEF = 10;

  localparam logic [DATA_WIDTH_DEF-1:0] Q_ONE   = DATA_WIDTH_DEF'(1) << QUANTIZED_BITS_DEF;
  localparam logic [DATA_WIDTH_DEF-1:0] FIX_MAX = {1'b0, {(DATA_WIDTH_DEF-1){1'b1}}};
  localparam logic [DATA_WIDTH_DEF-1:0] FIX_MIN = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_POST  = 3'd3,
    ST_OUT   = 3'd4
  } div_ctrl_state_t;

endpackage

// File: rtl/fixed_div_ctrl_sign_mag.sv
// fixed_sign_mag: combinational sign/magnitude helper for fixed_div_ctrl.
//   num_i, den_i   : signed Q operands
//   num_mag_o      : |num_i| zero-extended to DIV_WIDTH
//   den_mag_o      : |den_i| zero-extended to DIV_WIDTH
//   num_neg_o      : num_i is negative
//   res_neg_o      : quotient sign (num sign xor den sign)
//   mag_i, neg_i   : unsigned quotient magnitude and the sign to restore
//   res_o          : signed result, clamped to the DATA_WIDTH range
//   sat_o          : res_o was clamped
module fixed_sign_mag #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 43
) (
  input  logic [DATA_WIDTH-1:0] num_i,
  input  logic [DATA_WIDTH-1:0] den_i,
  output logic [DIV_WIDTH-1:0]  num_mag_o,
  output logic [DIV_WIDTH-1:0]  den_mag_o,
  output logic                  num_neg_o,
  output logic                  res_neg_o,
  input  logic [DIV_WIDTH-1:0]  mag_i,
  input  logic                  neg_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  sat_o
);

  localparam int EXT = DIV_WIDTH - DATA_WIDTH;

  // Largest magnitudes representable for each sign.
  localparam logic [DIV_WIDTH-1:0] POS_LIM = {{(EXT+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DIV_WIDTH-1:0] NEG_LIM = {{EXT{1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [DATA_WIDTH-1:0] RES_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] RES_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DIV_WIDTH-1:0] num_ext;
  logic [DIV_WIDTH-1:0] den_ext;

  // Sign-extend before negating so the most negative input yields an exact
  // magnitude instead of wrapping back to itself.
  assign num_ext   = {{EXT{num_i[DATA_WIDTH-1]}}, num_i};
  assign den_ext   = {{EXT{den_i[DATA_WIDTH-1]}}, den_i};
  assign num_mag_o = num_i[DATA_WIDTH-1] ? -num_ext : num_ext;
  assign den_mag_o = den_i[DATA_WIDTH-1] ? -den_ext : den_ext;
  assign num_neg_o = num_i[DATA_WIDTH-1];
  assign res_neg_o = num_i[DATA_WIDTH-1] ^ den_i[DATA_WIDTH-1];

  always_comb begin
    res_o = '0;
    sat_o = 1'b0;
    if (!neg_i) begin
      if (mag_i > POS_LIM) begin
        res_o = RES_MAX;
        sat_o = 1'b1;
      end else begin
        res_o = mag_i[DATA_WIDTH-1:0];
      end
    end else begin
      if (mag_i > NEG_LIM) begin
        res_o = RES_MIN;
        sat_o = 1'b1;
      end else begin
        // Low bits of -m equal -(low bits of m); m == 2^(W-1) lands on MIN.
        res_o = -mag_i[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fixed_div_ctrl.sv
// fixed_div_ctrl: signed Q-format division wrapper around an external
// iterative unsigned divider core.
//   clock, reset        : system clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready only in IDLE)
//   num, den            : signed Q dividend / divisor
//   out_valid/out_ready : result handshake, result held until accepted
//   out_quot            : signed Q quotient (truncated toward zero, saturated)
//   out_div_zero        : divisor was zero
//   out_sat             : quotient was clamped
//   div_valid_in        : one-cycle start pulse to the core
//   div_dividend        : |num| << QUANTIZED_BITS
//   div_divisor         : |den|
//   div_quotient        : core quotient, sampled on div_valid_out
//   div_valid_out       : core done pulse
//   dbg_state_o         : current controller state
//
// Handshake rule for both in_* and out_*: a transfer happens on a rising
// clock edge where valid and ready are both high; a valid source holds its
// data stable until that edge, and ready never depends on valid.
module fixed_div_ctrl
  import fixed_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int QUANTIZED_BITS = QUANTIZED_BITS_DEF
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                num,
  input  logic [DATA_WIDTH-1:0]                den,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_quot,
  output logic                                 out_div_zero,
  output logic                                 out_sat,
  output logic                                 div_valid_in,
  output logic [DATA_WIDTH+QUANTIZED_BITS:0]   div_dividend,
  output logic [DATA_WIDTH+QUANTIZED_BITS:0]   div_divisor,
  input  logic [DATA_WIDTH+QUANTIZED_BITS:0]   div_quotient,
  input  logic                                 div_valid_out,
  output div_ctrl_state_t                      dbg_state_o
);

  localparam int DIV_WIDTH = DATA_WIDTH + QUANTIZED_BITS + 1;

  localparam logic [DATA_WIDTH-1:0] RES_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] RES_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_ctrl_state_t       state_q,    state_d;
  logic                  neg_q,      neg_d;
  logic [DIV_WIDTH-1:0]  dividend_q, dividend_d;
  logic [DIV_WIDTH-1:0]  divisor_q,  divisor_d;
  logic [DIV_WIDTH-1:0]  quot_q,     quot_d;
  logic [DATA_WIDTH-1:0] res_q,      res_d;
  logic                  dz_q,       dz_d;
  logic                  sat_q,      sat_d;

  logic [DIV_WIDTH-1:0]  num_mag;
  logic [DIV_WIDTH-1:0]  den_mag;
  logic                  num_neg;
  logic                  res_neg;
  logic [DATA_WIDTH-1:0] post_res;
  logic                  post_sat;

  fixed_sign_mag #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIV_WIDTH  (DIV_WIDTH)
  ) u_sign_mag (
    .num_i     (num),
    .den_i     (den),
    .num_mag_o (num_mag),
    .den_mag_o (den_mag),
    .num_neg_o (num_neg),
    .res_neg_o (res_neg),
    .mag_i     (quot_q),
    .neg_i     (neg_q),
    .res_o     (post_res),
    .sat_o     (post_sat)
  );

  always_comb begin
    state_d    = state_q;
    neg_d      = neg_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    res_d      = res_q;
    dz_d       = dz_q;
    sat_d      = sat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          neg_d      = res_neg;
          dividend_d = num_mag << QUANTIZED_BITS;
          divisor_d  = den_mag;
          if (den == '0) begin
            // The core is bypassed; the result is fully known here.
            dz_d    = 1'b1;
            sat_d   = (num != '0);
            if (num == '0)   res_d = '0;
            else if (num_neg) res_d = RES_MIN;
            else              res_d = RES_MAX;
            state_d = ST_OUT;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (div_valid_out) begin
          quot_d  = div_quotient;
          state_d = ST_POST;
        end
      end
      ST_POST: begin
        res_d   = post_res;
        sat_d   = post_sat;
        dz_d    = 1'b0;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          dz_d    = 1'b0;
          sat_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      neg_q      <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      res_q      <= '0;
      dz_q       <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      neg_q      <= neg_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      res_q      <= res_d;
      dz_q       <= dz_d;
      sat_q      <= sat_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_OUT);
  assign div_valid_in = (state_q == ST_ISSUE);
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign out_quot     = res_q;
  assign out_div_zero = dz_q;
  assign out_sat      = sat_q;
  assign dbg_state_o  = state_q;

endmodule
